pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  - Owns the architectural PC register and fetches one instruction per step from instruction memory.
//  - Uses a req/gnt + rvalid handshake to memory.
//  - Presents PCaddress, PCincre and instr to the datapath and next-PC logic.
//  - Consumes PCnext and Halt from the next-PC stage; PCnext is loaded only on the single EXEC cycle.
// PARAMETERS
//  RESET_PC        32'h0000_0000  PC value loaded on reset
//  NOP_INSTR       32'h0000_0013  instr value while no fetched word is valid (addi x0,x0,0)
//  TIMEOUT_CYCLES  16             watchdog limit, used only with FETCH_TIMEOUT_EN
// PORTS
//  clk          in   1   single clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  PCnext       in   32  next PC from next-PC logic, sampled in EXEC
//  Halt         in   1   halt request from decode, sampled in EXEC
//  imem_req     out  1   fetch request
//  imem_addr    out  32  fetch address (= PCaddress)
//  imem_gnt     in   1   memory accepted request
//  imem_rvalid  in   1   instruction word valid
//  imem_rdata   in   32  instruction word
//  instr        out  32  latched instruction
//  instr_valid  out  1   1-cycle strobe: datapath executes instr this cycle
//  PCaddress    out  32  current PC
//  PCincre      out  32  PCaddress + 4, combinational, wraps mod 2^32
//  halted       out  1   sticky: core stopped
//  misalign     out  1   sticky: PCnext[1:0] != 0 was rejected
//  fetch_err    out  1   sticky watchdog error (tied 0 without FETCH_TIMEOUT_EN)
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - PC = RESET_PC, state = REQ, instr = NOP_INSTR.
//   - instr_valid, halted, misalign, fetch_err = 0; imem_req = 0 while rst is high.
//  State REQ:
//   - imem_req = 1, imem_addr = PC.
//   - Hold imem_req and imem_addr stable until imem_gnt; then go to WAIT.
//   - imem_rvalid in REQ is ignored.
//  State WAIT:
//   - imem_req = 0. On imem_rvalid: instr <= imem_rdata, go to EXEC.
//   - rvalid is never consumed in the cycle gnt is seen; earliest is the next cycle.
//  State EXEC (exactly 1 cycle):
//   - instr_valid = 1.
//   - If PCnext[1:0] != 0: misalign <= 1, halted <= 1, PC unchanged, go to HALT.
//   - Else if Halt: PC <= PCnext, halted <= 1, go to HALT.
//   - Else: PC <= PCnext, go to REQ.
//   - Misalign has priority over Halt.
//  State HALT:
//   - Absorbing; only rst exits. imem_req = 0, instr_valid = 0.
//   - instr keeps the last fetched word.
//  Latency:
//   - Minimum 3 cycles per instruction: REQ (gnt same cycle) -> WAIT (rvalid next cycle) -> EXEC.
//   - Each cycle of gnt/rvalid delay adds 1 cycle.
//  Reset mid-operation:
//   - The outstanding request is abandoned.
//   - Instruction memory shares rst, so no stale rvalid arrives after reset.
//  Back-to-back:
//   - imem_req rises in the cycle after EXEC; never asserted in EXEC or WAIT.
// CONFIGURATION
//  FETCH_TIMEOUT_EN defined:
//   - A counter runs in REQ/WAIT and clears on every state change.
//   - On reaching TIMEOUT_CYCLES without gnt (REQ) or rvalid (WAIT): fetch_err <= 1, halted <= 1, go to HALT.
//  FETCH_TIMEOUT_EN undefined:
//   - REQ/WAIT wait indefinitely; fetch_err is constant 0; no counter logic.
// TESTING
//  1. RESET_PC=0x100, gnt same cycle, rvalid next cycle with 0x00500093 -> imem_addr=0x100;
//     instr_valid on cycle 3 after reset release; instr=0x00500093; PCincre=0x104.
//  2. PCnext=0x200 in EXEC, Halt=0 -> PCaddress=0x200 next cycle; imem_req=1 with imem_addr=0x200.
//  3. gnt delayed 3 cycles, plus spurious rvalid while in REQ -> imem_req/imem_addr stable for 4 cycles;
//     spurious rvalid ignored; instr unaffected.
//  4. Halt=1 and PCnext=0x104 in EXEC -> halted=1, PCaddress=0x104, no imem_req for 20 cycles.
//     Then PCnext=0x202 after fresh reset -> misalign=1, halted=1, PCaddress held.
//  5. rst pulsed mid-WAIT -> PCaddress=RESET_PC, instr=NOP_INSTR, instr_valid=0;
//     REQ re-issued on the first cycle after release.
//  6. No rvalid for 16 cycles: with FETCH_TIMEOUT_EN -> fetch_err=1, halted=1;
//     without it -> still in WAIT, fetch_err=0.

Source files
------------

// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - instruction memory req/gnt + rvalid bus between fetch unit and imem
interface pc_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC register and one-instruction-per-step fetch FSM (REQ/WAIT/EXEC/HALT)
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR      = 32'h0000_0013,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  PCnext,
  input  logic         Halt,
  pc_fetch_unit_if.master imem,
  output logic [31:0]  instr,
  output logic         instr_valid,
  output logic [31:0]  PCaddress,
  output logic [31:0]  PCincre,
  output logic         halted,
  output logic         misalign,
  output logic         fetch_err
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_EXEC, S_HALT} state_t;

  state_t      state, state_next;
  logic [31:0] pc;
  logic        timed_out;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;
  logic          fetch_err_q;

  // Counts cycles spent in the current REQ/WAIT visit; any state change restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state != state_next) begin
      wait_cnt <= '0;
    end else if (state == S_REQ || state == S_WAIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timed_out = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign fetch_err = fetch_err_q;
`else
  assign timed_out = 1'b0;
  assign fetch_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_REQ;
    else     state <= state_next;
  end

  always_comb begin
    state_next    = state;
    instr_valid   = 1'b0;
    imem.imem_req = 1'b0;
    unique case (state)
      S_REQ: begin
        // Reset parks the FSM in REQ, so the request must be masked while rst is high.
        imem.imem_req = !rst;
        if (imem.imem_gnt)  state_next = S_WAIT;
        else if (timed_out) state_next = S_HALT;
      end
      S_WAIT: begin
        if (imem.imem_rvalid) state_next = S_EXEC;
        else if (timed_out)   state_next = S_HALT;
      end
      S_EXEC: begin
        instr_valid = 1'b1;
        if (PCnext[1:0] != 2'b00 || Halt) state_next = S_HALT;
        else                              state_next = S_REQ;
      end
      default: state_next = S_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      instr    <= NOP_INSTR;
      halted   <= 1'b0;
      misalign <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      fetch_err_q <= 1'b0;
`endif
    end else begin
      if (state == S_WAIT && imem.imem_rvalid) instr <= imem.imem_rdata;
      if (state == S_EXEC) begin
        // A misaligned target is refused outright and outranks a halt request.
        if (PCnext[1:0] != 2'b00) begin
          misalign <= 1'b1;
          halted   <= 1'b1;
        end else begin
          pc <= PCnext;
          if (Halt) halted <= 1'b1;
        end
      end
`ifdef FETCH_TIMEOUT_EN
      if (timed_out && ((state == S_REQ && !imem.imem_gnt) ||
                        (state == S_WAIT && !imem.imem_rvalid))) begin
        fetch_err_q <= 1'b1;
        halted      <= 1'b1;
      end
`endif
    end
  end

  assign imem.imem_addr = pc;
  assign PCaddress      = pc;
  assign PCincre        = pc + 32'd4;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - scoreboard bench for pc_fetch_unit fetch handshake, halt, misalign, reset
module tb_pc_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PCnext;
  logic        Halt;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] PCaddress;
  logic [31:0] PCincre;
  logic        halted;
  logic        misalign;
  logic        fetch_err;

  pc_fetch_unit_if imem_bus ();

  pc_fetch_unit #(
    .RESET_PC      (RESET_PC),
    .NOP_INSTR     (NOP),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .PCnext     (PCnext),
    .Halt       (Halt),
    .imem       (imem_bus),
    .instr      (instr),
    .instr_valid(instr_valid),
    .PCaddress  (PCaddress),
    .PCincre    (PCincre),
    .halted     (halted),
    .misalign   (misalign),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;
  exp_t sb[$];

  logic [31:0] model_pc;
  logic [31:0] model_instr;
  logic        model_halted;
  logic        model_misalign;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst                  = 1'b1;
    PCnext               = '0;
    Halt                 = 1'b0;
    imem_bus.imem_gnt    = 1'b0;
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_rdata  = '0;
    #1;
    check("rst_req", imem_bus.imem_req, 1'b0);
    check("rst_pc", PCaddress, RESET_PC);
    check("rst_instr", instr, NOP);
    check("rst_flags", {instr_valid, halted, misalign, fetch_err}, 4'b0000);
    @(negedge clk);
    rst            = 1'b0;
    model_pc       = RESET_PC;
    model_instr    = NOP;
    model_halted   = 1'b0;
    model_misalign = 1'b0;
    sb.delete();
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (imem_bus.imem_req === 1'b1) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  // Issue one complete fetch; the bench acts as instruction memory.
  task automatic fetch(input int gnt_dly, input bit spurious, input int rv_dly,
                       input logic [31:0] word, input logic [31:0] pcn, input logic halt);
    bit ok;
    exp_t e;
    wait_req(ok);
    check("req_seen", 32'(ok), 32'd1);
    if (!ok) return;
    check("req_addr", imem_bus.imem_addr, model_pc);
    for (int i = 0; i < gnt_dly; i++) begin
      imem_bus.imem_rvalid = spurious;
      imem_bus.imem_rdata  = 32'hdead_beef;
      @(negedge clk);
      #1;
      check("req_hold", {31'd0, imem_bus.imem_req}, 32'd1);
      check("addr_hold", imem_bus.imem_addr, model_pc);
      check("instr_hold", instr, model_instr);
    end
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_gnt    = 1'b1;
    @(negedge clk);
    imem_bus.imem_gnt = 1'b0;
    #1;
    check("wait_req_low", {31'd0, imem_bus.imem_req}, 32'd0);
    for (int i = 0; i < rv_dly; i++) begin
      @(negedge clk);
      #1;
      check("wait_quiet", {imem_bus.imem_req, instr_valid}, 2'b00);
    end
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata  = word;
    e.pc   = model_pc;
    e.word = word;
    sb.push_back(e);
    @(negedge clk);
    imem_bus.imem_rvalid = 1'b0;
    PCnext = pcn;
    Halt   = halt;
    #1;
    check("exec_valid", {31'd0, instr_valid}, 32'd1);
    check("exec_req_low", {31'd0, imem_bus.imem_req}, 32'd0);
    if (instr_valid === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      check("exec_instr", instr, e.word);
      check("exec_pc", PCaddress, e.pc);
      check("exec_pcincre", PCincre, e.pc + 32'd4);
    end
    @(negedge clk);
    model_instr = word;
    if (pcn[1:0] != 2'b00) begin
      model_halted   = 1'b1;
      model_misalign = 1'b1;
    end else begin
      model_pc = pcn;
      if (halt) model_halted = 1'b1;
    end
    #1;
    check("post_pc", PCaddress, model_pc);
    check("post_flags", {halted, misalign, instr_valid}, {model_halted, model_misalign, 1'b0});
    check("post_instr", instr, model_instr);
    if (!model_halted) begin
      check("b2b_req", {31'd0, imem_bus.imem_req}, 32'd1);
      check("b2b_addr", imem_bus.imem_addr, model_pc);
    end
  endtask

  task automatic check_parked(input string tag, input int cycles);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      #1;
      if (imem_bus.imem_req !== 1'b0 || instr_valid !== 1'b0 ||
          PCaddress !== model_pc || halted !== 1'b1) bad++;
    end
    check(tag, 32'(bad), 32'd0);
  endtask

  initial begin
    bit ok;
    // Reset, minimum-latency fetch, branch to 0x200, back-to-back request
    do_reset();
    fetch(0, 1'b0, 0, 32'h0050_0093, 32'h0000_0200, 1'b0);
    // Delayed gnt with spurious rvalid, then delayed rvalid, then halt
    fetch(3, 1'b1, 0, 32'h00a0_0113, 32'h0000_0204, 1'b0);
    fetch(1, 1'b0, 2, 32'h0020_8193, 32'h0000_0104, 1'b1);
    check_parked("halt_parked", 20);

    // Misaligned target after fresh reset
    do_reset();
    fetch(0, 1'b0, 1, 32'h0030_0213, 32'h0000_0202, 1'b0);
    check("misalign_flag", {31'd0, misalign}, 32'd1);
    check_parked("misalign_parked", 5);

    // Reset pulsed in WAIT abandons the outstanding fetch
    do_reset();
    fetch(0, 1'b0, 0, 32'h0040_0293, 32'h0000_0300, 1'b0);
    wait_req(ok);
    imem_bus.imem_gnt = 1'b1;
    @(negedge clk);
    imem_bus.imem_gnt = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_pc", PCaddress, RESET_PC);
    check("midrst_instr", instr, NOP);
    check("midrst_out", {imem_bus.imem_req, instr_valid}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_rereq", {31'd0, imem_bus.imem_req}, 32'd1);
    check("midrst_addr", imem_bus.imem_addr, RESET_PC);
    model_pc    = RESET_PC;
    model_instr = NOP;

    // Memory never answers: watchdog behaviour depends on build
    do_reset();
    wait_req(ok);
    imem_bus.imem_gnt = 1'b1;
    @(negedge clk);
    imem_bus.imem_gnt = 1'b0;
    repeat (16) @(negedge clk);
    #1;
`ifdef FETCH_TIMEOUT_EN
    check("timeout_flags", {fetch_err, halted}, 2'b11);
    model_halted = 1'b1;
    check_parked("timeout_parked", 4);
`else
    check("noto_flags", {fetch_err, halted, imem_bus.imem_req, instr_valid}, 4'b0000);
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata  = 32'h0060_0313;
    @(negedge clk);
    imem_bus.imem_rvalid = 1'b0;
    #1;
    check("noto_late_valid", {31'd0, instr_valid}, 32'd1);
    check("noto_late_instr", instr, 32'h0060_0313);
`endif
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
